// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: shares a single-port, word-addressed data memory between
// two requesters (m0 = core load/store, m1 = DMA/debug). Round-robin
// arbitration, byte-address to word-index conversion, read-modify-write for
// byte-enabled stores, and a registered, glitch-free write strobe with a full
// setup cycle ahead of it.
module dmem_arbiter_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic              m0_gnt,
  output logic              m0_done,
  // requester 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic              m1_gnt,
  output logic              m1_done,
  // shared response
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // memory pins
  output logic [31:0]       mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_WSETUP  = 3'd2;
  localparam logic [2:0] S_WSTROBE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // Controller state
  logic [2:0]        state_q,   state_d;
  logic              prio_q,    prio_d;    // id of the requester that wins a tie
  logic              owner_q,   owner_d;   // id of the requester being served
  logic              we_q,      we_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [BE_W-1:0]   be_q,      be_d;
  logic              oor_q,     oor_d;     // latched out-of-range flag
  logic [31:0]       mem_a_q,   mem_a_d;
  logic [DATA_W-1:0] mem_wd_q,  mem_wd_d;
  logic              mem_we_q,  mem_we_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              err_q,     err_d;

  // Arbitration results and the selected requester's fields
  logic              gnt0, gnt1, gnt_any;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_oor;

  // Read-modify-write helpers
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] merged;

  // Byte-offset bits are don't-care for a word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // Round-robin pick: only in IDLE; the priority holder wins a tie.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (m0_req && m1_req) begin
        gnt0 = ~prio_q;
        gnt1 =  prio_q;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;

  // Mux the granted requester's command fields.
  always_comb begin
    sel_we    = gnt1 ? m1_we    : m0_we;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_be    = gnt1 ? m1_be    : m0_be;
    sel_oor   = (sel_addr[31:2] >= 30'(DEPTH_WORDS));
  end

  // Expand byte enables into a bit mask and merge with the current word.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      byte_mask[i*8 +: 8] = {8{be_q[i]}};
    end
    merged = (mem_rd & ~byte_mask) | (wdata_q & byte_mask);
  end

  // Next-state and datapath logic for the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    oor_d    = oor_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    mem_we_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          owner_d = gnt1;
          prio_d  = ~gnt1;
          we_d    = sel_we;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          oor_d   = sel_oor;
          mem_a_d = 32'(sel_addr[IDX_W+1:2]);
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (oor_q) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (!we_q) begin
          err_d   = 1'b0;
          rdata_d = mem_rd;
          state_d = S_RESP;
        end else if (be_q == '0) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          err_d    = 1'b0;
          mem_wd_d = merged;
          state_d  = S_WSETUP;
        end
      end

      // Address and data already stable; raise the strobe for the next cycle.
      S_WSETUP: begin
        mem_we_d = 1'b1;
        state_d  = S_WSTROBE;
      end

      S_WSTROBE: begin
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including the write strobe.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      oor_q    <= 1'b0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
      mem_we_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      oor_q    <= oor_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      mem_we_q <= mem_we_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_done   = (state_q == S_RESP) && !owner_q;
  assign m1_done   = (state_q == S_RESP) &&  owner_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Directed testbench for dmem_arbiter_ctrl with a behavioural 256-word memory.
module tb_dmem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_ctrl #(.DATA_W(32), .DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_done(m1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  // Memory model: combinational read, write on the clock edge while strobed.
  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  // One transaction from a single requester; cycle 0 is the grant cycle.
  task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int exp_done_cyc, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic [31:0] exp_wd,
                         input string tag);
    bit got_gnt = 0;
    bit got_done = 0;
    int we_cnt = 0;
    int we_cyc = -1;
    bit exp_we = we && (exp_done_cyc == 4);
    logic [31:0] exp_a = {24'h0, addr[9:2]};
    @(posedge clk); #1 drive(m, 1'b1, we, addr, wdata, be);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_gnt : m1_gnt) begin got_gnt = 1; break; end
    end
    check({tag, "_gnt"}, 32'(got_gnt), 32'd1);
    if (got_gnt) begin
      // Only req is meaningful after the grant; scramble everything else.
      @(posedge clk); #1 drive(m, 1'b1, ~we, 32'hFFFF_FFF0, ~wdata, ~be);
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(negedge clk);
        if (cyc == 1) check({tag, "_mem_a"}, mem_a, exp_a);
        if (exp_we && cyc == 2) begin
          check({tag, "_setup_a"}, mem_a, exp_a);
          check({tag, "_setup_wd"}, mem_wd, exp_wd);
        end
        if (mem_we) begin we_cnt++; we_cyc = cyc; end
        if (m0_done || m1_done) begin
          got_done = 1;
          check({tag, "_done_who"}, {30'h0, m1_done, m0_done}, (m == 0) ? 32'd1 : 32'd2);
          check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
          check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
          if (!we) check({tag, "_rdata"}, rsp_rdata, exp_rdata);
          break;
        end
      end
      check({tag, "_done_seen"}, 32'(got_done), 32'd1);
      check({tag, "_we_cnt"}, 32'(we_cnt), exp_we ? 32'd1 : 32'd0);
      if (exp_we) check({tag, "_we_cyc"}, 32'(we_cyc), 32'd3);
      @(posedge clk); #1 drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  initial begin
    int order [3];
    int n_gnt;
    int n_done;
    bit seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hCAFE_F00D;
    mem[1]   = 32'h1122_3344;
    mem[4]   = 32'hDEAD_BEEF;
    mem[255] = 32'h0BAD_CAFE;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_hs", {28'h0, m1_gnt, m0_gnt, m1_done, m0_done}, 32'h0);
    check("rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed transactions (grant owners: m0 m1 m0 m0 m1 m0 m0 m1)
    run_txn(0, 1'b0, 32'h10,  32'h0,         4'h0,    2, 32'hDEAD_BEEF, 1'b0, 32'h0,         "rd_m0");
    run_txn(1, 1'b1, 32'h20,  32'h1234_5678, 4'hF,    4, 32'h0,         1'b0, 32'h1234_5678, "wr_full");
    check("mem8", mem[8], 32'h1234_5678);
    run_txn(0, 1'b0, 32'h20,  32'h0,         4'h0,    2, 32'h1234_5678, 1'b0, 32'h0,         "rd_back");
    run_txn(0, 1'b1, 32'h4,   32'hAABB_CCDD, 4'b0110, 4, 32'h0,         1'b0, 32'h11BB_CC44, "wr_part");
    check("mem1_part", mem[1], 32'h11BB_CC44);
    run_txn(1, 1'b1, 32'h4,   32'hFFFF_FFFF, 4'h0,    2, 32'h0,         1'b0, 32'h0,         "wr_be0");
    check("mem1_be0", mem[1], 32'h11BB_CC44);
    run_txn(0, 1'b1, 32'h400, 32'h9999_9999, 4'hF,    2, 32'h0,         1'b1, 32'h0,         "wr_oor");
    check("mem0_oor", mem[0], 32'hCAFE_F00D);
    run_txn(0, 1'b0, 32'h3FF, 32'h0,         4'h0,    2, 32'h0BAD_CAFE, 1'b0, 32'h0,         "rd_last");
    run_txn(1, 1'b0, 32'hFFFC,32'h0,         4'h0,    2, 32'h0,         1'b1, 32'h0,         "rd_oor");

    // Contention: both held high, priority currently with m0 -> m0, m1, m0
    n_gnt = 0;
    n_done = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 40 && n_done < 3; i++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) check("arb_double_gnt", 32'd1, 32'd0);
      if ((m0_gnt || m1_gnt) && n_gnt < 3) begin
        order[n_gnt] = m1_gnt ? 1 : 0;
        n_gnt++;
      end
      if (m0_done) begin check("arb_rd_m0", rsp_rdata, 32'hDEAD_BEEF); n_done++; end
      if (m1_done) begin check("arb_rd_m1", rsp_rdata, 32'h1234_5678); n_done++; end
      if (n_gnt == 3 && (m0_req || m1_req)) begin
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    check("arb_n_gnt", 32'(n_gnt), 32'd3);
    check("arb_n_done", 32'(n_done), 32'd3);
    if (n_gnt == 3) begin
      check("arb_order0", 32'(order[0]), 32'd0);
      check("arb_order1", 32'(order[1]), 32'd1);
      check("arb_order2", 32'(order[2]), 32'd0);
    end

    // Reset during the write strobe; priority is with m1 before the reset.
    @(posedge clk); #1 drive(0, 1'b1, 1'b1, 32'h30, 32'h55, 4'hF);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) begin seen = 1; break; end
    end
    check("rstw_strobe_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_we_drop", 32'(mem_we), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_done", {30'h0, m1_done, m0_done}, 32'h0);
    end
    check("rstw_mem12", mem[12], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    check("rstw_gnt_m0", {30'h0, m1_gnt, m0_gnt}, 32'd1);
    @(posedge clk); #1 drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_done) begin seen = 1; check("rstw_rd", rsp_rdata, 32'hDEAD_BEEF); break; end
    end
    check("rstw_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("end_idle", {30'h0, busy, m1_gnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
